// File: rtl/riscv_pkg.sv
// Shared definitions for the 5-stage RISC-V core: widths, reset PC, the NOP
// encoding and the prefetch FIFO entry layout.
package riscv_pkg;

  localparam int unsigned     XLEN      = 32;
  localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0]     NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO between the instruction-memory response port and the IF/ID
// register. Clear has priority over a same-cycle push.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  fetch_entry_t                 push_data,
  input  logic                         pop,
  input  logic                         clear,
  output fetch_entry_t                 pop_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t       mem_q [DEPTH];
  fetch_entry_t       mem_d [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  // Push on a full FIFO is only accepted when a pop frees the head slot.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/fetch_stage.sv
// IF stage and IF/ID register: PC, credit-limited imem requests, discard of
// wrong-path responses after a redirect, and the decode-facing pipeline register.
module fetch_stage #(
  parameter int unsigned            XLEN       = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0]        RESET_PC   = riscv_pkg::RESET_PC,
  parameter int unsigned            FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            StallF,
  input  logic            StallD,
  input  logic            FlushD,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD
);

  import riscv_pkg::*;

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OCC_W = CNT_W + 1;

  logic [XLEN-1:0]  pcf_q, pcf_d;
  logic [XLEN-1:0]  resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [31:0]      instr_d_q, instr_d_d;
  logic [XLEN-1:0]  pc_d_q, pc_d_d;
  logic [XLEN-1:0]  pc_plus4_d_q, pc_plus4_d_d;
  logic             valid_d_q, valid_d_d;

  logic [XLEN-1:0]  redirect_pc;
  logic [OCC_W-1:0] occupancy;
  logic             grant, resp, resp_drop, resp_keep;
  logic             fifo_pop, fifo_empty, fifo_full;
  logic [CNT_W-1:0] fifo_count;
  fetch_entry_t     fifo_head, fifo_in;

  assign redirect_pc = PCTargetE & ~XLEN'(3);
  assign fifo_pop    = !FlushD && !StallD && !fifo_empty;

  // The slot freed by this cycle's pop is credited immediately so a
  // zero-wait memory sustains one fetch per cycle with a 2-entry FIFO.
  assign occupancy = OCC_W'(fifo_count) - OCC_W'(fifo_pop) + OCC_W'(outstanding_q);
  assign imem_req  = rst_n && !StallF && !PCSrcE && !(fifo_full && !fifo_pop)
                     && (occupancy < OCC_W'(FIFO_DEPTH));
  assign imem_addr = pcf_q;

  assign grant     = imem_req && imem_gnt;
  assign resp      = imem_rvalid && (outstanding_q != '0);
  assign resp_drop = resp && (drop_cnt_q != '0);
  assign resp_keep = resp && !resp_drop;
  assign fifo_in   = '{pc: resp_pc_q, instr: imem_rdata};

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (resp_keep),
    .push_data (fifo_in),
    .pop       (fifo_pop),
    .clear     (PCSrcE),
    .pop_data  (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  // resp_pc tracks the PC of the next response that will be kept.
  always_comb begin
    pcf_d         = pcf_q;
    resp_pc_d     = resp_pc_q;
    outstanding_d = outstanding_q + CNT_W'(grant) - CNT_W'(resp);
    drop_cnt_d    = drop_cnt_q - CNT_W'(resp_drop);
    if (grant) begin
      pcf_d = pcf_q + XLEN'(4);
    end
    if (resp_keep) begin
      resp_pc_d = resp_pc_q + XLEN'(4);
    end
    if (PCSrcE) begin
      pcf_d      = redirect_pc;
      resp_pc_d  = redirect_pc;
      drop_cnt_d = outstanding_d;
    end
  end

  always_comb begin
    instr_d_d    = instr_d_q;
    pc_d_d       = pc_d_q;
    pc_plus4_d_d = pc_plus4_d_q;
    valid_d_d    = valid_d_q;
    if (FlushD) begin
      valid_d_d = 1'b0;
      instr_d_d = NOP_INSTR;
    end else if (!StallD) begin
      if (!fifo_empty) begin
        valid_d_d    = 1'b1;
        instr_d_d    = fifo_head.instr;
        pc_d_d       = fifo_head.pc;
        pc_plus4_d_d = fifo_head.pc + XLEN'(4);
      end else begin
        valid_d_d = 1'b0;
        instr_d_d = NOP_INSTR;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcf_q         <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      instr_d_q     <= NOP_INSTR;
      pc_d_q        <= '0;
      pc_plus4_d_q  <= XLEN'(4);
      valid_d_q     <= 1'b0;
    end else begin
      pcf_q         <= pcf_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      instr_d_q     <= instr_d_d;
      pc_d_q        <= pc_d_d;
      pc_plus4_d_q  <= pc_plus4_d_d;
      valid_d_q     <= valid_d_d;
    end
  end

  assign InstrD   = instr_d_q;
  assign PCD      = pc_d_q;
  assign PCPlus4D = pc_plus4_d_q;
  assign ValidD   = valid_d_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a bench-side instruction memory with
// configurable latency and a queue-level model of fetch, buffering and decode.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n, StallF, StallD, FlushD, PCSrcE;
  logic [31:0] PCTargetE;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata, InstrD, PCD, PCPlus4D;
  logic        ValidD;

  always #5 clk = ~clk;

  fetch_stage #(
    .XLEN       (32),
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .StallF      (StallF),
    .StallD      (StallD),
    .FlushD      (FlushD),
    .PCSrcE      (PCSrcE),
    .PCTargetE   (PCTargetE),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .InstrD      (InstrD),
    .PCD         (PCD),
    .PCPlus4D    (PCPlus4D),
    .ValidD      (ValidD)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // stimulus knobs
  logic        s_rst_n = 1'b0, s_stallf = 1'b0, s_stalld = 1'b0, s_flushd = 1'b0;
  logic        s_pcsrc = 1'b0, s_gnt = 1'b1, s_stray = 1'b0;
  logic [31:0] s_target = '0;
  int          s_lat = 1;

  // bench memory: granted requests awaiting their response
  logic [31:0] mq_addr[$];
  int          mq_due[$];

  // model state
  logic [31:0] m_pc;
  logic [31:0] m_inflight[$];
  bit          m_doomed[$];
  logic [31:0] m_buf[$];
  logic        m_valid;
  logic [31:0] m_instr, m_pcd, m_pcp4;
  logic [31:0] exp_next_pc;
  bit          loaded_last;
  int          n_delivered = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0013;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (cycle %0d): timed out waiting", name, cyc);
  endtask

  task automatic model_reset();
    m_pc = 32'h0;
    m_inflight.delete();
    m_doomed.delete();
    m_buf.delete();
    m_valid = 1'b0;
    m_instr = 32'h0000_0013;
    m_pcd = 32'h0;
    m_pcp4 = 32'h4;
    exp_next_pc = 32'h0;
    loaded_last = 1'b0;
    mq_addr.delete();
    mq_due.delete();
  endtask

  task automatic tick();
    bit          pop, exp_req, grant, stray_now;
    logic [31:0] e;
    @(negedge clk);
    rst_n     = s_rst_n;
    StallF    = s_stallf;
    StallD    = s_stalld;
    FlushD    = s_flushd;
    PCSrcE    = s_pcsrc;
    PCTargetE = s_target;
    imem_gnt  = s_gnt;
    stray_now = s_stray;
    if (stray_now) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
    end else if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(mq_addr[0]);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
    #1;
    if (!rst_n) begin
      check("rst_ValidD", {31'b0, ValidD}, 32'h0);
      check("rst_InstrD", InstrD, 32'h0000_0013);
      check("rst_PCD", PCD, 32'h0);
      check("rst_PCPlus4D", PCPlus4D, 32'h4);
      check("rst_imem_req", {31'b0, imem_req}, 32'h0);
      model_reset();
    end else begin
      pop     = !FlushD && !StallD && (m_buf.size() > 0);
      exp_req = !StallF && !PCSrcE && ((m_buf.size() - int'(pop) + m_inflight.size()) < 2);
      check("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
      check("imem_addr", imem_addr, m_pc);
      check("ValidD", {31'b0, ValidD}, {31'b0, m_valid});
      check("InstrD", InstrD, m_instr);
      check("PCD", PCD, m_pcd);
      check("PCPlus4D", PCPlus4D, m_pcp4);
      check("outstanding_le_depth", {31'b0, mq_addr.size() <= 2}, 32'h1);
      if (loaded_last && ValidD) begin
        check("program_order", PCD, exp_next_pc);
        exp_next_pc += 32'h4;
        n_delivered++;
      end
      loaded_last = !FlushD && !StallD;

      grant = exp_req && imem_gnt;
      if (FlushD) begin
        m_valid = 1'b0;
        m_instr = 32'h0000_0013;
      end else if (!StallD) begin
        if (pop) begin
          e       = m_buf.pop_front();
          m_valid = 1'b1;
          m_instr = mem_word(e);
          m_pcd   = e;
          m_pcp4  = e + 32'h4;
        end else begin
          m_valid = 1'b0;
          m_instr = 32'h0000_0013;
        end
      end
      if (imem_rvalid && m_inflight.size() > 0) begin
        e = m_inflight.pop_front();
        if (!m_doomed.pop_front()) m_buf.push_back(e);
      end
      if (PCSrcE) begin
        m_buf.delete();
        foreach (m_doomed[i]) m_doomed[i] = 1'b1;
        m_pc        = s_target & ~32'h3;
        exp_next_pc = s_target & ~32'h3;
      end else if (grant) begin
        m_inflight.push_back(m_pc);
        m_doomed.push_back(1'b0);
        m_pc += 32'h4;
      end

      if (imem_rvalid && !stray_now) begin
        void'(mq_addr.pop_front());
        void'(mq_due.pop_front());
      end
      if (imem_req && imem_gnt) begin
        mq_addr.push_back(imem_addr);
        mq_due.push_back(cyc + s_lat);
      end
    end
    cyc++;
  endtask

  task automatic wait_valid(input string name);
    int k = 0;
    do begin
      tick();
      k++;
    end while (!ValidD && k < 60);
    if (!ValidD) timeout_fail(name);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic redirect(input logic [31:0] tgt);
    s_pcsrc = 1'b1; s_flushd = 1'b1; s_target = tgt;
    tick();
    s_pcsrc = 1'b0; s_flushd = 1'b0;
  endtask

  logic [31:0] exp_pcd_tbl [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
  logic [31:0] exp_ins_tbl [4] = '{32'hC0DE_0013, 32'hC0DE_0017, 32'hC0DE_001B, 32'hC0DE_001F};

  initial begin
    logic [31:0] hold_pc;
    int          k, start;
    rst_n = 1'b0; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0;
    PCTargetE = '0; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    model_reset();

    // reset, then free-run on a zero-wait memory
    run(2);
    s_rst_n = 1'b1;
    tick();
    check("c1_imem_req", {31'b0, imem_req}, 32'h1);
    check("c1_imem_addr", imem_addr, 32'h0);
    tick();
    check("c2_ValidD", {31'b0, ValidD}, 32'h0);
    tick();
    check("c3_ValidD", {31'b0, ValidD}, 32'h0);
    check("c3_InstrD", InstrD, 32'h0000_0013);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("stream_ValidD", {31'b0, ValidD}, 32'h1);
      check("stream_PCD", PCD, exp_pcd_tbl[i]);
      check("stream_InstrD", InstrD, exp_ins_tbl[i]);
    end

    // 3-cycle response latency, 20 fetches
    s_lat = 3;
    start = n_delivered;
    k = 0;
    while (n_delivered < start + 20 && k < 300) begin
      tick();
      k++;
    end
    if (n_delivered < start + 20) timeout_fail("latency3_20_fetches");

    // redirect to 0x100 with two fetches in flight
    k = 0;
    while (m_inflight.size() != 2 && k < 20) begin
      tick();
      k++;
    end
    if (m_inflight.size() != 2) timeout_fail("two_in_flight");
    redirect(32'h100);
    tick();
    check("flush_ValidD", {31'b0, ValidD}, 32'h0);
    check("flush_InstrD", InstrD, 32'h0000_0013);
    check("redirect_addr", imem_addr, 32'h100);
    wait_valid("redirect_first_valid");
    check("redirect_PCD", PCD, 32'h100);
    check("redirect_InstrD", InstrD, 32'hC0DE_0113);

    // StallD + StallF for three cycles on a steady stream
    s_lat = 1;
    run(8);
    hold_pc = m_pcd;
    check("prestall_ValidD", {31'b0, ValidD}, 32'h1);
    s_stalld = 1'b1; s_stallf = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_imem_req", {31'b0, imem_req}, 32'h0);
      check("stall_PCD", PCD, hold_pc);
      check("stall_InstrD", InstrD, mem_word(hold_pc));
    end
    s_stalld = 1'b0; s_stallf = 1'b0;
    tick();
    check("release_PCD", PCD, hold_pc);
    run(6);

    // misaligned target and PC wrap
    redirect(32'h203);
    tick();
    check("aligned_addr", imem_addr, 32'h200);
    run(4);
    redirect(32'hFFFF_FFFC);
    wait_valid("wrap_first_valid");
    check("wrap_PCD", PCD, 32'hFFFF_FFFC);
    check("wrap_PCPlus4D", PCPlus4D, 32'h0);
    tick();
    check("wrap_next_PCD", PCD, 32'h0);

    // reset mid-burst with rvalid pulsing, then a stray response
    s_lat = 3;
    run(5);
    s_rst_n = 1'b0; s_stray = 1'b1;
    tick();
    s_stray = 1'b0;
    tick();
    s_stray = 1'b1;
    tick();
    s_rst_n = 1'b1; s_stallf = 1'b1;
    tick();
    s_stray = 1'b0;
    run(2);
    check("stray_ValidD", {31'b0, ValidD}, 32'h0);
    check("stray_InstrD", InstrD, 32'h0000_0013);
    s_stallf = 1'b0;
    wait_valid("post_reset_first_valid");
    check("post_reset_PCD", PCD, 32'h0);
    check("post_reset_InstrD", InstrD, 32'hC0DE_0013);
    run(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
